// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line-wide pmem port between I-cache and D-cache.
// Ports: clk/rst, i_* (read), d_* (read/writeback), pmem_* (to memory/L2).
`timescale 1ns/1ps
module cache_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RECOVER
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SW-1:0]     d_streak;
  logic [SW-1:0]     d_streak_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [ADDR_W-1:0] lat_addr_nxt;
  logic [LINE_W-1:0] lat_wdata;
  logic [LINE_W-1:0] lat_wdata_nxt;
  logic              lat_write;
  logic              lat_write_nxt;

  logic d_req;
  logic i_force;
  logic grant_d;
  logic grant_i;
  logic serving;

  assign d_req   = d_read | d_write;
  // I is forced once D has won MAX_D_STREAK times in a row over a waiting I
  assign i_force = i_read && (d_streak == STREAK_MAX);
  assign grant_d = (state == IDLE) && d_req && !i_force;
  assign grant_i = (state == IDLE) && i_read && !grant_d;
  assign serving = (state == SERVE_I) || (state == SERVE_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      d_streak  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
    end else begin
      state     <= state_nxt;
      d_streak  <= d_streak_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
      lat_write <= lat_write_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    d_streak_nxt  = d_streak;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    lat_write_nxt = lat_write;
    i_resp        = 1'b0;
    d_resp        = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          grant_d: begin
            state_nxt     = SERVE_D;
            lat_addr_nxt  = d_address;
            lat_wdata_nxt = d_wdata;
            // write wins over an illegal simultaneous read
            lat_write_nxt = d_write;
            if (i_read && (d_streak != STREAK_MAX))
              d_streak_nxt = d_streak + 1'b1;
          end
          grant_i: begin
            state_nxt     = SERVE_I;
            lat_addr_nxt  = i_address;
            lat_wdata_nxt = '0;
            lat_write_nxt = 1'b0;
            d_streak_nxt  = '0;
          end
          default: begin
            state_nxt = IDLE;
          end
        endcase
      end
      SERVE_I: begin
        if (pmem_resp) begin
          i_resp    = 1'b1;
          state_nxt = RECOVER;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          d_resp    = 1'b1;
          state_nxt = RECOVER;
        end
      end
      RECOVER: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // strobes depend only on state and the latched op
  assign pmem_read    = serving && !lat_write;
  assign pmem_write   = serving && lat_write;
  assign pmem_address = lat_addr;
  assign pmem_wdata   = lat_wdata;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(d_read && d_write))
        else $warning("cache_arbiter: d_read and d_write both high");
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed stimulus, transaction-level model and
// per-cycle compare for cache_arbiter.
`timescale 1ns/1ps
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  cache_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int nvec = 0;
  int nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // pmem responder: resp after lat strobe cycles, held for hold cycles
  bit auto_en = 1'b0;
  bit man_resp = 1'b0;
  int lat = 1;
  int hold = 1;
  int cnt = 0;
  int left = 0;

  always @(posedge clk) begin
    #2;
    if (pmem_read || pmem_write) cnt++;
    else cnt = 0;
    if (auto_en && cnt == lat + 1) left = hold;
    if (left > 0) begin
      pmem_resp = 1'b1;
      left--;
    end else begin
      pmem_resp = man_resp;
    end
    pmem_rdata = {8{$urandom}};
  end

  // transaction-level model: who owns pmem, what was captured
  int           m_owner = 0;
  bit           m_gap = 1'b0;
  int           m_streak = 0;
  logic [31:0]  m_addr = '0;
  logic [255:0] m_wdata = '0;
  bit           m_wr = 1'b0;
  bit           known = 1'b0;

  always @(negedge clk) begin
    if (known) begin
      chk("pmem_read", pmem_read,
          (m_owner == 1) || (m_owner == 2 && !m_wr));
      chk("pmem_write", pmem_write, m_owner == 2 && m_wr);
      chk("pmem_address", pmem_address, m_addr);
      chk("pmem_wdata", pmem_wdata, m_wdata);
      chk("i_resp", i_resp, m_owner == 1 && pmem_resp);
      chk("d_resp", d_resp, m_owner == 2 && pmem_resp);
      if (i_resp) chk("i_rdata", i_rdata, pmem_rdata);
      if (d_resp) chk("d_rdata", d_rdata, pmem_rdata);
    end
    if (rst) begin
      known    = 1'b1;
      m_owner  = 0;
      m_gap    = 1'b0;
      m_streak = 0;
      m_addr   = '0;
      m_wdata  = '0;
      m_wr     = 1'b0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        m_owner = 0;
        m_gap   = 1'b1;
      end
    end else if ((d_read || d_write) &&
                 !(i_read && m_streak == 4)) begin
      m_owner = 2;
      m_addr  = d_address;
      m_wdata = d_wdata;
      m_wr    = d_write;
      if (i_read && m_streak < 4) m_streak++;
    end else if (i_read) begin
      m_owner  = 1;
      m_addr   = i_address;
      m_wdata  = '0;
      m_wr     = 1'b0;
      m_streak = 0;
    end
  end

  // grant observer: address at every rising pmem strobe
  bit          rec_en = 1'b0;
  bit          prev_strobe = 1'b0;
  logic [31:0] obs_q[$];

  always @(negedge clk) begin
    if (rec_en && (pmem_read || pmem_write) && !prev_strobe)
      obs_q.push_back(pmem_address);
    prev_strobe = pmem_read || pmem_write;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input bit for_d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (for_d ? d_resp : i_resp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_g[6];
  bit          ok;
  int          n_i;
  int          n_d;
  bit          seen;

  initial begin
    rst = 1'b1;
    i_read = 0; i_address = '0;
    d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pread", pmem_read, 0);
    chk("rst_pwrite", pmem_write, 0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_iresp", i_resp, 0);
    chk("rst_dresp", d_resp, 0);

    // 1: lone I read, resp 5 cycles after the strobe rises
    lat = 5; hold = 1; auto_en = 1;
    step();
    i_read = 1; i_address = 32'h0000_1000;
    for (int c = 1; c <= 6; c++) begin
      step();
      @(negedge clk);
      chk("t1_pread", pmem_read, 1);
      chk("t1_addr", pmem_address, 32'h1000);
      chk("t1_iresp", i_resp, c == 6);
      chk("t1_dresp", d_resp, 0);
    end
    step();
    i_read = 0;
    @(negedge clk);
    chk("t1_recover_pread", pmem_read, 0);
    chk("t1_recover_iresp", i_resp, 0);
    step();
    @(negedge clk);
    chk("t1_idle_pread", pmem_read, 0);

    // 2: lone D write, inputs change mid-transaction
    lat = 3;
    step();
    d_write = 1; d_address = 32'h8000_0040;
    d_wdata = {32{8'hA5}};
    step();
    d_address = 32'h1234_5678; d_wdata = '0;
    @(negedge clk);
    chk("t2_pwrite", pmem_write, 1);
    chk("t2_pread", pmem_read, 0);
    chk("t2_addr", pmem_address, 32'h8000_0040);
    chk("t2_wdata", pmem_wdata, {32{8'hA5}});
    wait_resp(1'b1, ok);
    chk("t2_resp_seen", ok, 1);
    chk("t2_addr_at_resp", pmem_address, 32'h8000_0040);
    step();
    d_write = 0;
    step();

    // 3: both requesters held from reset
    lat = 1;
    rst = 1;
    i_read = 1; i_address = 32'h100;
    d_read = 1; d_address = 32'h200;
    obs_q.delete();
    rec_en = 1;
    step();
    step();
    rst = 0;
    repeat (30) step();
    rec_en = 0;
    i_read = 0; d_read = 0;
    repeat (8) step();
    exp_g = '{32'h200, 32'h200, 32'h200, 32'h200,
              32'h100, 32'h200};
    chk("t3_grants", obs_q.size() >= 6, 1);
    if (obs_q.size() >= 6)
      for (int k = 0; k < 6; k++)
        chk($sformatf("t3_grant%0d", k), obs_q[k], exp_g[k]);

    // 4: reset in the middle of SERVE_D, then a stray resp
    auto_en = 0;
    d_read = 1; d_address = 32'h3000;
    step();
    @(negedge clk);
    chk("t4_pread", pmem_read, 1);
    step();
    rst = 1; d_read = 0;
    step();
    rst = 0;
    @(negedge clk);
    chk("t4_post_pread", pmem_read, 0);
    chk("t4_post_pwrite", pmem_write, 0);
    chk("t4_post_addr", pmem_address, 0);
    step();
    man_resp = 1;
    @(negedge clk);
    chk("t4_stray_dresp", d_resp, 0);
    chk("t4_stray_iresp", i_resp, 0);
    step();
    man_resp = 0;
    step();

    // 5: illegal read+write, write wins
    auto_en = 1; lat = 2;
    step();
    d_read = 1; d_write = 1; d_address = 32'h4000;
    d_wdata = {8{32'h0BAD_F00D}};
    step();
    @(negedge clk);
    chk("t5_pwrite", pmem_write, 1);
    chk("t5_pread", pmem_read, 0);
    wait_resp(1'b1, ok);
    chk("t5_resp_seen", ok, 1);
    step();
    d_read = 0; d_write = 0;
    step();
    step();

    // 6: pmem_resp held for 3 cycles
    lat = 2; hold = 3;
    obs_q.delete();
    rec_en = 1;
    n_i = 0; n_d = 0; seen = 0;
    step();
    i_read = 1; i_address = 32'h5000;
    for (int k = 0; k < 12; k++) begin
      step();
      if (seen) i_read = 0;
      @(negedge clk);
      if (i_resp) begin
        n_i++;
        seen = 1;
      end
      if (d_resp) n_d++;
    end
    rec_en = 0;
    hold = 1;
    chk("t6_iresp_pulses", n_i, 1);
    chk("t6_dresp_pulses", n_d, 0);
    chk("t6_grants", obs_q.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
